// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling behind a 2-FF synchroniser.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the parityErr strobe.
module uart_rx #(
    parameter int unsigned CLK_FREQ     = 27_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dataIn,
    output logic [7:0] dataOut,
    output logic       valid,
    output logic       busy,
    output logic       frameErr,
    output logic       parityErr
);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic [7:0]    dataOut_q;
    logic          armed_q;
    logic          valid_q;
    logic          busy_q;
    logic          frameErr_q;
    logic          rxS;
`ifdef UART_RX_PARITY_EN
    logic          parBit_q;
    logic          parityErr_q;
    logic          parityOk;

    assign parityOk  = ~^{shift_q, parBit_q};
    assign parityErr = parityErr_q;
`else
    assign parityErr = 1'b0;
`endif

    assign rxS      = sync_q[1];
    assign dataOut  = dataOut_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign frameErr = frameErr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            dataOut_q   <= '0;
            armed_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBit_q    <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], dataIn};
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // A start edge only counts once the line has been seen idle-high.
                    if (rxS) armed_q <= 1'b1;
                    if (armed_q && !rxS) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (rxS) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= S_DATA;
                            bitIdx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q    <= '0;
                        shift_q  <= {rxS, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 1'b1;
                        if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q    <= '0;
                        parBit_q <= rxS;
                        state_q  <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (!rxS) begin
                            frameErr_q <= 1'b1;
                            armed_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        end else if (!parityOk) begin
                            parityErr_q <= 1'b1;
`endif
                        end else begin
                            dataOut_q <= shift_q;
                            valid_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
